// File: rtl/bridge_data_loader.sv
// Turns 32-bit APF bridge writes into evenly paced, narrower memory writes.
// Bridge words pass a 2-stage ingress pipeline into a FIFO; a sequencer emits their sub-words lowest address first.
module bridge_data_loader #(
    parameter int ADDRESS_SIZE              = 15,
    parameter int OUTPUT_WORD_SIZE          = 2,
    parameter int WRITE_MEM_CLOCK_DELAY     = 10,
    parameter int WRITE_MEM_EN_CYCLE_LENGTH = 1,
    parameter int FIFO_DEPTH                = 16
) (
    input  logic                          clk_74a,
    input  logic                          reset,
    input  logic                          bridge_wr,
    input  logic                          bridge_endian_little,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
    output logic                          write_en,
    output logic [ADDRESS_SIZE-1:0]       write_addr,
    output logic [8*OUTPUT_WORD_SIZE-1:0] write_data
);

    localparam int OW   = 8 * OUTPUT_WORD_SIZE;
    localparam int NSUB = 4 / OUTPUT_WORD_SIZE;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(WRITE_MEM_CLOCK_DELAY);
    localparam int EW   = ADDRESS_SIZE + 32;

    localparam logic [CW-1:0] EN_LAST  = CW'(WRITE_MEM_EN_CYCLE_LENGTH - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(WRITE_MEM_CLOCK_DELAY - 1);
    localparam logic [1:0]    SUB_LAST = 2'(NSUB - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    // Byte k of the result is always the byte at bridge_addr+k.
    function automatic logic [31:0] normalise(input logic [31:0] d, input logic le);
        return le ? d : {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic unused_addr_bits;
    assign unused_addr_bits = ^bridge_addr[31:ADDRESS_SIZE];

    logic          s1_valid, s2_valid;
    logic [EW-1:0] s1_entry, s2_entry;

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_entry <= '0;
            s2_entry <= '0;
        end else begin
            s1_valid <= bridge_wr;
            s1_entry <= {bridge_addr[ADDRESS_SIZE-1:0], normalise(bridge_wr_data, bridge_endian_little)};
            s2_valid <= s1_valid;
            s2_entry <= s1_entry;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, fifo_count;
    logic          fifo_empty, fifo_full, push, pop;
    logic [EW-1:0] head;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign push       = s2_valid && !fifo_full;
    assign head       = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_74a) begin
        if (push) mem[wr_ptr[PW-1:0]] <= s2_entry;
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sub_left;
    logic [31:0]   shift_data;
    logic          slot_done;

    // cnt counts cycles since write_en rose, so the slot ends exactly WRITE_MEM_CLOCK_DELAY after it.
    assign slot_done = (state == WAIT) && (cnt == DLY_LAST);
    assign pop       = !fifo_empty && ((state == IDLE) || (slot_done && sub_left == 2'd0));

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sub_left   <= '0;
            shift_data <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else if (pop) begin
            state      <= WRITE;
            cnt        <= '0;
            sub_left   <= SUB_LAST;
            write_en   <= 1'b1;
            write_addr <= head[EW-1:32];
            write_data <= head[OW-1:0];
            shift_data <= head[31:0] >> OW;
        end else if (slot_done && sub_left != 2'd0) begin
            state      <= WRITE;
            cnt        <= '0;
            sub_left   <= sub_left - 2'd1;
            write_en   <= 1'b1;
            write_addr <= write_addr + ADDRESS_SIZE'(OUTPUT_WORD_SIZE);
            write_data <= shift_data[OW-1:0];
            shift_data <= shift_data >> OW;
        end else if (slot_done) begin
            state <= IDLE;
        end else if (state == WRITE) begin
            cnt <= cnt + 1'b1;
            if (cnt == EN_LAST) begin
                write_en <= 1'b0;
                state    <= WAIT;
            end
        end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bridge_data_loader.sv
// Self-checking bench for bridge_data_loader: directed vector table, hand sequences and
// randomized traffic checked against a transaction-level timing model.
module tb_bridge_data_loader;

    localparam int AW    = 15;
    localparam int OWS   = 2;
    localparam int D     = 10;
    localparam int ENL   = 1;
    localparam int DEPTH = 16;
    localparam int NSUB  = 4 / OWS;
    localparam int DW    = 8 * OWS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bridge_wr = 1'b0;
    logic          bridge_endian_little = 1'b0;
    logic [31:0]   bridge_addr = '0;
    logic [31:0]   bridge_wr_data = '0;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;

    bridge_data_loader #(
        .ADDRESS_SIZE(AW), .OUTPUT_WORD_SIZE(OWS), .WRITE_MEM_CLOCK_DELAY(D),
        .WRITE_MEM_EN_CYCLE_LENGTH(ENL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_74a(clk), .reset(reset), .bridge_wr(bridge_wr),
        .bridge_endian_little(bridge_endian_little), .bridge_addr(bridge_addr),
        .bridge_wr_data(bridge_wr_data), .write_en(write_en),
        .write_addr(write_addr), .write_data(write_data)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            edge_n;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pop_q[$];
    int  seq_free = 0;
    int  n_vec = 0;
    int  n_bad = 0;
    int  n_writes = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a word captured at edge cap reaches the FIFO at cap+2 unless the FIFO already holds
    // DEPTH words; it is popped at the first edge after that where the sequencer is free, and its
    // sub-writes rise at the pop edge and every D edges after.
    function automatic void model_word(input logic [31:0] a, input logic [31:0] d,
                                       input logic le, input int cap);
        int        p, occ, e;
        logic [7:0] b [4];
        wr_t       w;
        p   = cap + 2;
        occ = 0;
        foreach (pop_q[i]) if (pop_q[i] >= p) occ++;
        if (occ >= DEPTH) return;
        e = (p + 1 > seq_free) ? p + 1 : seq_free;
        pop_q.push_back(e);
        seq_free = e + NSUB * D;
        for (int k = 0; k < 4; k++) b[k] = le ? d[8*k +: 8] : d[8*(3-k) +: 8];
        for (int j = 0; j < NSUB; j++) begin
            w.edge_n = e + j * D;
            w.addr   = AW'(a + 32'(j * OWS));
            w.data   = '0;
            for (int m = 0; m < OWS; m++) w.data[8*m +: 8] = b[j*OWS + m];
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pop_q.delete();
        seq_free  = 0;
        hold_addr = '0;
        hold_data = '0;
    endfunction

    // ---------------- output monitor ----------------
    logic en_prev = 1'b0;
    int   hi_len  = 0;
    always @(negedge clk) begin
        if (reset) begin
            en_prev = 1'b0;
            hi_len  = 0;
        end else begin
            if (write_en && !en_prev) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(write_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_edge", 32'(cyc), 32'(w.edge_n));
                    check("wr_addr", 32'(write_addr), 32'(w.addr));
                    check("wr_data", 32'(write_data), 32'(w.data));
                    hold_addr = w.addr;
                    hold_data = w.data;
                end
            end
            if (write_en) begin
                hi_len++;
            end else begin
                if (en_prev) check("en_width", 32'(hi_len), 32'(ENL));
                hi_len = 0;
                check("hold_addr", 32'(write_addr), 32'(hold_addr));
                check("hold_data", 32'(write_data), 32'(hold_data));
            end
            en_prev = write_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_word(input logic [31:0] a, input logic [31:0] d, input logic le);
        bridge_wr            = 1'b1;
        bridge_addr          = a;
        bridge_wr_data       = d;
        bridge_endian_little = le;
        model_word(a, d, le, cyc + 1);
        @(posedge clk); #2;
        bridge_wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2 * D) @(posedge clk);
        #2;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic          le;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
    } vec_t;

    vec_t tab [5];

    initial begin
        int cap;
        tab[0] = '{32'h0000_000C, 32'hAABB_CCDD, 1'b0, 15'h000C, 16'hBBAA, 15'h000E, 16'hDDCC};
        tab[1] = '{32'h0000_0020, 32'hFFEE_DDCC, 1'b0, 15'h0020, 16'hEEFF, 15'h0022, 16'hCCDD};
        tab[2] = '{32'h0000_0100, 32'hAABB_CCDD, 1'b1, 15'h0100, 16'hCCDD, 15'h0102, 16'hAABB};
        tab[3] = '{32'h0000_7FFE, 32'h1122_3344, 1'b0, 15'h7FFE, 16'h2211, 15'h0000, 16'h4433};
        tab[4] = '{32'hFFFF_8010, 32'h0102_0304, 1'b1, 15'h0010, 16'h0304, 15'h0012, 16'h0102};

        // Reset held with no traffic, then a quiet window after release.
        repeat (10) @(posedge clk);
        #2;
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        reset = 1'b0;
        n_writes = 0;
        repeat (20) @(posedge clk);
        #2;
        check("quiet_after_reset", 32'(n_writes), 32'd0);

        // Table: each word alone into an idle loader, first write 3 edges after capture.
        for (int i = 0; i < 5; i++) begin
            bridge_wr            = 1'b1;
            bridge_addr          = tab[i].addr;
            bridge_wr_data       = tab[i].data;
            bridge_endian_little = tab[i].le;
            cap = cyc + 1;
            exp_q.push_back('{cap + 3, tab[i].a0, tab[i].d0});
            exp_q.push_back('{cap + 3 + D, tab[i].a1, tab[i].d1});
            pop_q.push_back(cap + 3);
            seq_free = cap + 3 + NSUB * D;
            @(posedge clk); #2;
            bridge_wr = 1'b0;
            wait_drain(200);
        end

        // Burst of five back-to-back words.
        n_writes = 0;
        for (int i = 0; i < 5; i++) drive_word(32'(4 * i), $urandom, 1'(i & 1));
        wait_drain(400);
        check("burst_writes", 32'(n_writes), 32'(5 * NSUB));

        // Overfill: DEPTH+3 back-to-back words; one goes straight to the sequencer, DEPTH fill the FIFO.
        n_writes = 0;
        for (int i = 0; i < DEPTH + 3; i++) drive_word(32'h200 + 32'(4 * i), $urandom, 1'b0);
        wait_drain(1000);
        check("overfill_writes", 32'(n_writes), 32'((DEPTH + 1) * NSUB));

        // Reset between the two sub-word writes of one word.
        drive_word(32'h40, 32'h1234_5678, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_write_en", 32'(write_en), 32'd0);
        check("midrst_write_addr", 32'(write_addr), 32'd0);
        check("midrst_write_data", 32'(write_data), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        n_writes = 0;
        repeat (4 * D) @(posedge clk);
        #2;
        check("midrst_no_writes", 32'(n_writes), 32'd0);

        // Randomized traffic against the model, including occasional FIFO overflow.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                drive_word($urandom, $urandom, 1'($urandom_range(0, 1)));
            else begin
                @(posedge clk); #2;
            end
        end
        wait_drain(2 * DEPTH * NSUB * D + 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time guard in case some wait above never returns.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
